dw_up_arbiter: RTL

- Round-robin arbiter that shares one dw_up_converter between NUM_REQ narrow (INPUT_DW) streams.
- Locks the grant on word boundaries, so every wide output word holds UP_RATIO beats from a single requester.
- Sits directly in front of the converter's data_i/valid_i/ready_o port.
- Publishes the owner ID so downstream logic can tag each wide word.

---
 rtl/dw_up_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dw_up_arbiter.sv
// ============================================================================
// dw_up_arbiter : round-robin arbiter that locks the grant on wide-word boundaries
// Rev 1.0
// ============================================================================
`default_nettype none

module dw_up_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int INPUT_DW  = 64,
    parameter int OUTPUT_DW = 512,
    parameter int MAX_WORDS = 4,
    parameter int UP_RATIO  = OUTPUT_DW / INPUT_DW,
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [NUM_REQ*INPUT_DW-1:0] in_data_i,
    input  logic [NUM_REQ-1:0]          in_valid_i,
    output logic [NUM_REQ-1:0]          in_ready_o,
    output logic [INPUT_DW-1:0]         out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        gnt_valid_o,
    output logic [ID_W-1:0]             gnt_id_o,
    output logic                        word_done_o
);

    localparam int BEAT_W = (UP_RATIO > 1) ? $clog2(UP_RATIO) : 1;
    localparam int WORD_W = $clog2(MAX_WORDS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(UP_RATIO - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(MAX_WORDS - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    generate
        if (OUTPUT_DW % INPUT_DW != 0) begin : g_chk_dw
            $fatal(1, "OUTPUT_DW must be a multiple of INPUT_DW");
        end
        if (UP_RATIO < 2) begin : g_chk_ratio
            $fatal(1, "UP_RATIO must be at least 2");
        end
        if (NUM_REQ < 2) begin : g_chk_req
            $fatal(1, "NUM_REQ must be at least 2");
        end
        if (MAX_WORDS < 1) begin : g_chk_words
            $fatal(1, "MAX_WORDS must be at least 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;

    logic                locked;
    logic [INPUT_DW-1:0] own_data;
    logic                own_valid;
    logic                handshake;
    logic                word_done;
    logic                release_grant;
    logic [ID_W-1:0]     winner;
    logic                found;

    assign locked = (state_q == S_LOCKED);

    // Owner mux; compares against the loop index so a non-power-of-2
    // NUM_REQ never selects a slice that does not exist.
    always_comb begin
        own_data   = '0;
        own_valid  = 1'b0;
        in_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == gnt_id_q) begin
                own_data      = in_data_i[k*INPUT_DW +: INPUT_DW];
                own_valid     = in_valid_i[k];
                in_ready_o[k] = locked & out_ready_i;
            end
        end
    end

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && in_valid_i[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign handshake   = locked & own_valid & out_ready_i;
    assign word_done   = handshake & (beat_cnt_q == LAST_BEAT);
    // Forced release takes precedence, but both paths lead to the same rr_ptr.
    assign release_grant = locked &
                           ((word_done & (word_cnt_q == LAST_WORD)) |
                            ((beat_cnt_q == '0) & ~own_valid));

    assign out_data_o  = locked ? own_data : '0;
    assign out_valid_o = locked & own_valid;
    assign gnt_valid_o = locked;
    assign gnt_id_o    = locked ? gnt_id_q : '0;
    assign word_done_o = word_done;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_LOCKED;
                    gnt_id_d   = winner;
                    beat_cnt_d = '0;
                    word_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (handshake) begin
                    beat_cnt_d = word_done ? '0 : beat_cnt_q + BEAT_W'(1);
                    if (word_done) word_cnt_d = word_cnt_q + WORD_W'(1);
                end
                if (release_grant) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

`default_nettype wire
